pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter BRANCH_STAGE, default 3, stage resolving branches (2=EX, 3=MEM); other values are illegal.
REQ-003 SHALL have parameter CNT_W, default 32, width of each performance counter.
REQ-004 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports id_rs1, id_rs2  in  REG_W  source indices of the instruction in ID.
REQ-007 SHALL have ports id_use_rs1, id_use_rs2  in  1  source actually read by the ID instruction.
REQ-008 SHALL have ports ex_rd  in  REG_W and ex_memread  in  1  destination and load flag of the EX instruction.
REQ-009 SHALL have ports mem_rd  in  REG_W and mem_regwrite  in  1  MEM-stage writeback info.
REQ-010 SHALL have ports wb_rd  in  REG_W and wb_regwrite  in  1  WB-stage writeback info.
REQ-011 SHALL have port branch_taken  in  1  taken branch resolved in stage BRANCH_STAGE.
REQ-012 SHALL have port ex_busy  in  1  multi-cycle EX unit not finished.
REQ-013 SHALL have ports pc_write, if_id_write, id_ex_write  out  1  register-enables for PC, IF/ID and ID/EX.
REQ-014 SHALL have ports if_id_flush, id_ex_bubble, ex_mem_bubble  out  1  force a NOP into the named pipeline register.
REQ-015 SHALL have port ex_kill  out  1  cancel the in-flight multi-cycle EX operation.
REQ-016 SHALL have ports fwd_a, fwd_b  out  2  operand selects: 00 regfile, 01 WB result, 10 MEM result.
REQ-017 SHALL have port stage_valid  out  4  valid bits {WB,MEM,EX,ID}.
REQ-018 SHALL have port state  out  2  action of the previous cycle: 0 RUN, 1 STALL, 2 FREEZE, 3 FLUSH.
REQ-019 SHALL have port perf_cnt  out  3*CNT_W  {flush_cnt, stall_cnt, retire_cnt}; present only when PERF_CNT_EN is defined.

Function
REQ-020 Per-cycle action SHALL be chosen by priority: FLUSH (branch_taken) > FREEZE (ex_busy) > STALL (load-use) > RUN.
REQ-021 Load-use SHALL be ex_memread && ex_rd!=0 && ((id_use_rs1 && id_rs1==ex_rd) || (id_use_rs2 && id_rs2==ex_rd)).
REQ-022 RUN: all write enables 1, all bubbles/flush/kill 0.
REQ-023 STALL: pc_write=0, if_id_write=0, id_ex_bubble=1; each load-use event SHALL stall exactly one cycle.
REQ-024 FREEZE: pc_write=if_id_write=id_ex_write=0, ex_mem_bubble=1.
REQ-025 FLUSH: pc_write=1, if_id_flush=1, id_ex_bubble=1; additionally ex_mem_bubble=1 and ex_kill=1 when BRANCH_STAGE=3.
REQ-026 Forwarding SHALL be combinational: MEM match (mem_regwrite, mem_rd!=0, mem_rd==src) selects 10, else WB match selects 01, else 00; index 0 never forwarded.
REQ-027 stage_valid SHALL advance per action: RUN shifts in ID=1; STALL holds ID, clears EX; FREEZE holds ID/EX, clears MEM; FLUSH clears the stages younger than BRANCH_STAGE.
REQ-028 state SHALL register the action of the current cycle at the next rising edge.
REQ-029 retire_cnt SHALL increment each cycle stage_valid[3]=1; stall_cnt on every STALL or FREEZE cycle; flush_cnt once per FLUSH cycle; all wrap modulo 2^CNT_W.

Reset
REQ-030 While reset=1: stage_valid=0, state=RUN, counters=0, fwd_a=fwd_b=00, all flush/bubble/kill outputs 0, write enables 1.
REQ-031 reset asserted mid-FREEZE or mid-FLUSH SHALL abort it; the first cycle after release SHALL be RUN with stage_valid=0.

Configuration
REQ-032 With PERF_CNT_EN defined, the counters and perf_cnt SHALL exist; without it, both are absent and all other behaviour is identical.

Verification
REQ-033 ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle pc_write=0, id_ex_bubble=1, then RUN, state=1 then 0.
REQ-034 mem_rd=wb_rd=7, both regwrite=1, id_rs2=7 -> fwd_b=10; mem_regwrite=0 -> fwd_b=01; rd=0 -> fwd_b=00.
REQ-035 branch_taken=1 with load-use pending, BRANCH_STAGE=3 -> FLUSH only, pc_write=1, ex_kill=1, stage_valid -> 4'b1000 when WB valid.
REQ-036 ex_busy=1 for 4 cycles -> 4 FREEZE cycles, stall_cnt +4, 4 bubbles into EX/MEM.
REQ-037 retire_cnt preset to 2^CNT_W-1 with WB valid -> wraps to 0; reset mid-FREEZE -> all outputs at reset values.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: chooses one action per cycle (FLUSH > FREEZE > STALL > RUN), drives forwarding selects and tracks stage validity.
// Optional performance counters are compiled in when PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int REG_W        = 5,
  parameter int BRANCH_STAGE = 3,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_regwrite,
  input  logic             branch_taken,
  input  logic             ex_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             ex_kill,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [3:0]       stage_valid,
  output logic [1:0]       state
`ifdef PERF_CNT_EN
  ,
  output logic [3*CNT_W-1:0] perf_cnt
`endif
);

  typedef enum logic [1:0] {
    ACT_RUN    = 2'd0,
    ACT_STALL  = 2'd1,
    ACT_FREEZE = 2'd2,
    ACT_FLUSH  = 2'd3
  } action_t;

  // A branch resolved in MEM also has a wrong-path instruction sitting in EX.
  localparam bit BR_IN_MEM = (BRANCH_STAGE == 3);

  action_t    action;
  action_t    action_p1;
  logic [3:0] valid_p1;
  logic [3:0] valid_nxt;
  logic       load_use;

  function automatic logic [1:0] fwd_sel(
    input logic [REG_W-1:0] src,
    input logic [REG_W-1:0] m_rd,
    input logic             m_we,
    input logic [REG_W-1:0] w_rd,
    input logic             w_we
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (m_we && (m_rd != '0) && (m_rd == src))
      sel = 2'b10;
    else if (w_we && (w_rd != '0) && (w_rd == src))
      sel = 2'b01;
    return sel;
  endfunction

  // The stall is suppressed right after a STALL so a single load-use event costs exactly one cycle.
  always_comb begin
    load_use = ex_memread && (ex_rd != '0) &&
               ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));
    if (reset)
      action = ACT_RUN;
    else if (branch_taken)
      action = ACT_FLUSH;
    else if (ex_busy)
      action = ACT_FREEZE;
    else if (load_use && (action_p1 != ACT_STALL))
      action = ACT_STALL;
    else
      action = ACT_RUN;
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    ex_kill       = 1'b0;
    valid_nxt     = {valid_p1[2:0], 1'b1};
    unique case (action)
      ACT_STALL: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        valid_nxt    = {valid_p1[2:1], 1'b0, valid_p1[0]};
      end
      ACT_FREEZE: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_bubble = 1'b1;
        valid_nxt     = {valid_p1[2], 1'b0, valid_p1[1:0]};
      end
      ACT_FLUSH: begin
        if_id_flush   = 1'b1;
        id_ex_bubble  = 1'b1;
        ex_mem_bubble = BR_IN_MEM;
        ex_kill       = BR_IN_MEM;
        valid_nxt     = {valid_p1[2], (BR_IN_MEM ? 1'b0 : valid_p1[1]), 2'b00};
      end
      default: ;
    endcase
  end

  assign fwd_a       = reset ? 2'b00 : fwd_sel(id_rs1, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
  assign fwd_b       = reset ? 2'b00 : fwd_sel(id_rs2, mem_rd, mem_regwrite, wb_rd, wb_regwrite);
  assign stage_valid = reset ? 4'b0000 : valid_p1;
  assign state       = reset ? ACT_RUN : action_p1;

  // Stage boundary: action and validity registered for the next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      action_p1 <= ACT_RUN;
      valid_p1  <= 4'b0000;
    end else begin
      action_p1 <= action;
      valid_p1  <= valid_nxt;
    end
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] retire_cnt;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      retire_cnt <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      if (valid_p1[3])
        retire_cnt <= retire_cnt + 1'b1;
      if ((action == ACT_STALL) || (action == ACT_FREEZE))
        stall_cnt <= stall_cnt + 1'b1;
      if (action == ACT_FLUSH)
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign perf_cnt = reset ? '0 : {flush_cnt, stall_cnt, retire_cnt};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: driver pushes hand-computed expectations, a monitor pops and compares on the falling edge.
module tb_pipeline_hazard_ctrl;
  localparam int REG_W = 5;
  localparam int CNT_W = 4;

  localparam logic [6:0] RUN_C    = 7'b1110000;
  localparam logic [6:0] STALL_C  = 7'b0010100;
  localparam logic [6:0] FREEZE_C = 7'b0000010;
  localparam logic [6:0] FLUSH_C  = 7'b1111111;

  logic clk, reset;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_memread, mem_regwrite, wb_regwrite, branch_taken, ex_busy;
  logic pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, ex_mem_bubble, ex_kill;
  logic [1:0] fwd_a, fwd_b, state;
  logic [3:0] stage_valid;
`ifdef PERF_CNT_EN
  logic [3*CNT_W-1:0] perf_cnt;
`endif

  pipeline_hazard_ctrl #(.REG_W(REG_W), .BRANCH_STAGE(3), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .branch_taken(branch_taken), .ex_busy(ex_busy),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble), .ex_mem_bubble(ex_mem_bubble),
    .ex_kill(ex_kill), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stage_valid(stage_valid), .state(state)
`ifdef PERF_CNT_EN
    , .perf_cnt(perf_cnt)
`endif
  );

  typedef struct {
    string      name;
    logic [6:0] ctrl;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [3:0] sv;
    logic [1:0] st;
    bit         chk_perf;
    logic [11:0] perf;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    reset = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_rd = '0; ex_memread = 1'b0; mem_rd = '0; mem_regwrite = 1'b0;
    wb_rd = '0; wb_regwrite = 1'b0; branch_taken = 1'b0; ex_busy = 1'b0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic load_use_on();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
  endtask

  task automatic expect_now(input string n, input logic [6:0] c, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [3:0] sv, input logic [1:0] st,
                            input bit cp = 1'b0, input logic [11:0] p = 12'h000);
    exp_t e;
    e.name = n; e.ctrl = c; e.fa = fa; e.fb = fb; e.sv = sv; e.st = st;
    e.chk_perf = cp; e.perf = p;
    q.push_back(e);
  endtask

  // Monitor: the DUT presents a full output set every cycle; compare whenever an expectation is pending.
  initial begin
    exp_t e;
    logic [6:0] act;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        act = {pc_write, if_id_write, id_ex_write, if_id_flush, id_ex_bubble, ex_mem_bubble, ex_kill};
        checks++;
        if (act !== e.ctrl || fwd_a !== e.fa || fwd_b !== e.fb ||
            stage_valid !== e.sv || state !== e.st) begin
          errors++;
          $display("FAIL %s: got ctrl=%b fwd_a=%b fwd_b=%b stage_valid=%b state=%0d, expected ctrl=%b fwd_a=%b fwd_b=%b stage_valid=%b state=%0d",
                   e.name, act, fwd_a, fwd_b, stage_valid, state, e.ctrl, e.fa, e.fb, e.sv, e.st);
        end
`ifdef PERF_CNT_EN
        if (e.chk_perf) begin
          checks++;
          if (perf_cnt !== e.perf) begin
            errors++;
            $display("FAIL %s_perf: got perf_cnt=%h, expected %h", e.name, perf_cnt, e.perf);
          end
        end
`endif
      end
    end
  end

  initial begin
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;
    // Reset held with every hazard input active: outputs must stay at reset values.
    load_use_on(); branch_taken = 1'b1; ex_busy = 1'b1;
    mem_rd = 5'd7; mem_regwrite = 1'b1; id_rs2 = 5'd7; id_rs1 = 5'd5;
    expect_now("reset_hold", RUN_C, 2'b00, 2'b00, 4'b0000, 2'd0, 1'b1, 12'h000);

    cyc(); expect_now("run_fill0", RUN_C, 2'b00, 2'b00, 4'b0000, 2'd0);
    cyc(); expect_now("run_fill1", RUN_C, 2'b00, 2'b00, 4'b0001, 2'd0, 1'b1, 12'h000);
    cyc(); expect_now("run_fill2", RUN_C, 2'b00, 2'b00, 4'b0011, 2'd0);
    cyc(); expect_now("run_fill3", RUN_C, 2'b00, 2'b00, 4'b0111, 2'd0);
    cyc(); load_use_on(); expect_now("load_use_stall", STALL_C, 2'b00, 2'b00, 4'b1111, 2'd0);
    cyc(); load_use_on(); expect_now("stall_once", RUN_C, 2'b00, 2'b00, 4'b1101, 2'd1, 1'b1, 12'h011);
    cyc(); ex_memread = 1'b1; ex_rd = 5'd6; id_rs2 = 5'd6;
    expect_now("rs2_unused_no_stall", RUN_C, 2'b00, 2'b00, 4'b1011, 2'd0);
    cyc(); ex_memread = 1'b1; ex_rd = 5'd0; id_use_rs1 = 1'b1;
    mem_rd = 5'd7; mem_regwrite = 1'b1; wb_rd = 5'd7; wb_regwrite = 1'b1; id_rs2 = 5'd7;
    expect_now("fwd_b_mem", RUN_C, 2'b00, 2'b10, 4'b0111, 2'd0);
    cyc(); mem_rd = 5'd7; wb_rd = 5'd7; wb_regwrite = 1'b1; id_rs2 = 5'd7;
    expect_now("fwd_b_wb", RUN_C, 2'b00, 2'b01, 4'b1111, 2'd0);
    cyc(); mem_regwrite = 1'b1; wb_regwrite = 1'b1; id_rs2 = 5'd7;
    expect_now("fwd_b_rd0", RUN_C, 2'b00, 2'b00, 4'b1111, 2'd0);
    cyc(); id_rs1 = 5'd9; id_rs2 = 5'd7; mem_rd = 5'd4; mem_regwrite = 1'b1; wb_rd = 5'd9; wb_regwrite = 1'b1;
    expect_now("fwd_a_wb", RUN_C, 2'b01, 2'b00, 4'b1111, 2'd0);
    cyc(); id_rs1 = 5'd9; id_rs2 = 5'd7; mem_rd = 5'd9; mem_regwrite = 1'b1; wb_rd = 5'd9; wb_regwrite = 1'b1;
    expect_now("fwd_a_mem_prio", RUN_C, 2'b10, 2'b00, 4'b1111, 2'd0);
    cyc(); load_use_on(); branch_taken = 1'b1;
    expect_now("flush_over_stall", FLUSH_C, 2'b00, 2'b00, 4'b1111, 2'd0);
    cyc(); expect_now("after_flush", RUN_C, 2'b00, 2'b00, 4'b1000, 2'd3, 1'b1, 12'h118);
    cyc(); expect_now("refill", RUN_C, 2'b00, 2'b00, 4'b0001, 2'd0);
    cyc(); ex_busy = 1'b1; expect_now("freeze1", FREEZE_C, 2'b00, 2'b00, 4'b0011, 2'd0);
    cyc(); ex_busy = 1'b1; expect_now("freeze2", FREEZE_C, 2'b00, 2'b00, 4'b0011, 2'd2);
    cyc(); ex_busy = 1'b1; load_use_on();
    expect_now("freeze3_over_stall", FREEZE_C, 2'b00, 2'b00, 4'b0011, 2'd2);
    cyc(); ex_busy = 1'b1; expect_now("freeze4", FREEZE_C, 2'b00, 2'b00, 4'b0011, 2'd2);
    cyc(); expect_now("after_freeze", RUN_C, 2'b00, 2'b00, 4'b0011, 2'd2, 1'b1, 12'h159);
    cyc(); expect_now("run21", RUN_C, 2'b00, 2'b00, 4'b0111, 2'd0);
    for (int i = 22; i <= 27; i++) begin
      cyc(); expect_now("run_full", RUN_C, 2'b00, 2'b00, 4'b1111, 2'd0);
    end
    cyc(); expect_now("retire_max", RUN_C, 2'b00, 2'b00, 4'b1111, 2'd0, 1'b1, 12'h15F);
    cyc(); expect_now("retire_wrap", RUN_C, 2'b00, 2'b00, 4'b1111, 2'd0, 1'b1, 12'h150);
    cyc(); ex_busy = 1'b1; expect_now("freeze_pre_reset", FREEZE_C, 2'b00, 2'b00, 4'b1111, 2'd0, 1'b1, 12'h151);
    cyc(); reset = 1'b1; ex_busy = 1'b1; branch_taken = 1'b1;
    mem_rd = 5'd7; mem_regwrite = 1'b1; id_rs2 = 5'd7;
    expect_now("reset_mid_freeze", RUN_C, 2'b00, 2'b00, 4'b0000, 2'd0, 1'b1, 12'h000);
    cyc(); expect_now("post_reset_run", RUN_C, 2'b00, 2'b00, 4'b0000, 2'd0, 1'b1, 12'h000);
    cyc(); branch_taken = 1'b1; expect_now("flush_pre_reset", FLUSH_C, 2'b00, 2'b00, 4'b0001, 2'd0);
    cyc(); reset = 1'b1; branch_taken = 1'b1;
    expect_now("reset_mid_flush", RUN_C, 2'b00, 2'b00, 4'b0000, 2'd0);
    cyc(); expect_now("post_reset_run2", RUN_C, 2'b00, 2'b00, 4'b0000, 2'd0);

    repeat (4) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
